// File: rtl/vga_sprite_gen.sv
// Bouncing-square pixel generator behind a 640x480 VGA timing driver, 2-cycle pipeline.
// Optional checkerboard background enabled by defining VGA_SPRITE_CHECKER_EN.
module vga_sprite_gen #(
    parameter int SIZE      = 32,
    parameter int STEP      = 2,
    parameter int H_VISIBLE = 640,
    parameter int V_VISIBLE = 480
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       en,
    input  logic [9:0] h_count,
    input  logic [9:0] v_count,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_tick
);

    localparam logic [10:0] SIZE_W = 11'(SIZE);
    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [9:0]  STEP_N = 10'(STEP);
    localparam logic [10:0] H_W    = 11'(H_VISIBLE);
    localparam logic [10:0] V_W    = 11'(V_VISIBLE);

    // Sprite motion state: position, direction (1 = left/up) and palette index.
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       dx_left;
        logic       dy_up;
        logic [2:0] colour_idx;
    } motion_t;

    motion_t     mot;
    motion_t     mot_next;
    logic [10:0] step_x;
    logic [10:0] step_y;
    logic        upd;
    logic [10:0] h_w;
    logic [10:0] v_w;
    logic [10:0] x_w;
    logic [10:0] y_w;
    logic        vis_d;
    logic        in_spr_d;

    logic        vis1;
    logic        in_spr1;
    logic        hs1;
    logic        vs1;
    logic [11:0] bg_colour;
    logic [11:0] pix_d;

    // No handshake: one pixel accepted and produced per cycle with en high, no backpressure.
    assign upd = en && (h_count == 10'd0) && ({1'b0, v_count} == V_W);

    // Returns {flip, new_position} for one axis bounded by [0, limit-SIZE].
    function automatic logic [10:0] axis_step(input logic [9:0] pos, input logic back,
                                              input logic [10:0] limit);
        logic [10:0] fwd;
        fwd = {1'b0, pos} + STEP_W;
        if (!back) begin
            if (fwd + SIZE_W <= limit) axis_step = {1'b0, fwd[9:0]};
            else                       axis_step = {1'b1, 10'(limit - SIZE_W)};
        end else begin
            if ({1'b0, pos} >= STEP_W) axis_step = {1'b0, pos - STEP_N};
            else                       axis_step = {1'b1, 10'd0};
        end
    endfunction

    function automatic logic [11:0] palette(input logic [2:0] idx);
        case (idx)
            3'd0:    palette = 12'hF00;
            3'd1:    palette = 12'h0F0;
            3'd2:    palette = 12'h00F;
            3'd3:    palette = 12'hFF0;
            3'd4:    palette = 12'h0FF;
            3'd5:    palette = 12'hF0F;
            3'd6:    palette = 12'hFFF;
            default: palette = 12'hF80;
        endcase
    endfunction

    always_comb begin
        step_x   = axis_step(mot.x, mot.dx_left, H_W);
        step_y   = axis_step(mot.y, mot.dy_up, V_W);
        mot_next = mot;
        mot_next.x       = step_x[9:0];
        mot_next.y       = step_y[9:0];
        mot_next.dx_left = mot.dx_left ^ step_x[10];
        mot_next.dy_up   = mot.dy_up ^ step_y[10];
        // A corner hit flips both axes but still advances the colour only once.
        if (step_x[10] || step_y[10]) mot_next.colour_idx = mot.colour_idx + 3'd1;
    end

    always_comb begin
        h_w      = {1'b0, h_count};
        v_w      = {1'b0, v_count};
        x_w      = {1'b0, mot.x};
        y_w      = {1'b0, mot.y};
        vis_d    = (h_w < H_W) && (v_w < V_W);
        in_spr_d = (x_w <= h_w) && (h_w < x_w + SIZE_W) &&
                   (y_w <= v_w) && (v_w < y_w + SIZE_W);
    end

`ifdef VGA_SPRITE_CHECKER_EN
    logic tile1;

    always_ff @(posedge clk or posedge arst) begin
        if (arst)    tile1 <= 1'b0;
        else if (en) tile1 <= h_count[5] ^ v_count[5];
    end

    assign bg_colour = tile1 ? 12'h444 : 12'h000;
`else
    assign bg_colour = 12'h000;
`endif

    always_comb begin
        pix_d = 12'h000;
        if (vis1) pix_d = in_spr1 ? palette(mot.colour_idx) : bg_colour;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            mot        <= '0;
            vis1       <= 1'b0;
            in_spr1    <= 1'b0;
            hs1        <= 1'b0;
            vs1        <= 1'b0;
            red        <= 4'h0;
            green      <= 4'h0;
            blue       <= 4'h0;
            hsync      <= 1'b0;
            vsync      <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= upd;
            if (en) begin
                vis1    <= vis_d;
                in_spr1 <= in_spr_d;
                hs1     <= hsync_in;
                vs1     <= vsync_in;
                {red, green, blue} <= pix_d;
                hsync   <= hs1;
                vsync   <= vs1;
                // Update point sits in vertical blank, so no visible pixel sees a move.
                if (upd) mot <= mot_next;
            end
        end
    end

endmodule

// File: tb/tb_vga_sprite_gen.sv
// Randomised scoreboard bench for vga_sprite_gen against a frame-level sprite model.
module tb_vga_sprite_gen;

    localparam int SIZE  = 32;
    localparam int STEP  = 2;
    localparam int H_VIS = 640;
    localparam int V_VIS = 480;

    logic       clk = 1'b0;
    logic       arst = 1'b0;
    logic       en = 1'b0;
    logic [9:0] h_count = '0;
    logic [9:0] v_count = '0;
    logic       hsync_in = 1'b0;
    logic       vsync_in = 1'b0;
    logic [3:0] red, green, blue;
    logic       hsync, vsync, frame_tick;

    vga_sprite_gen #(.SIZE(SIZE), .STEP(STEP), .H_VISIBLE(H_VIS), .V_VISIBLE(V_VIS)) dut (
        .clk(clk), .arst(arst), .en(en), .h_count(h_count), .v_count(v_count),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync), .frame_tick(frame_tick)
    );

    always #20 clk = ~clk;

    // Expected output word: {rgb[11:0], hsync, vsync}.
    logic [13:0] exp_q[$];
    logic [13:0] hold_exp = '0;
    int errors = 0;
    int checks = 0;

    int mx, my, mdx, mdy, mcol;
    bit last_flip;
    logic [11:0] pal [8] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
                             12'h0FF, 12'hF0F, 12'hFFF, 12'hF80};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] ref_pixel(input int h, input int v);
        if (h >= H_VIS || v >= V_VIS) return 12'h000;
        if (h >= mx && h < mx + SIZE && v >= my && v < my + SIZE) return pal[mcol];
`ifdef VGA_SPRITE_CHECKER_EN
        if ((((h / 32) ^ (v / 32)) % 2) == 1) return 12'h444;
`endif
        return 12'h000;
    endfunction

    task automatic model_reset();
        mx = 0; my = 0; mdx = 1; mdy = 1; mcol = 0;
        exp_q.delete();
        hold_exp = '0;
    endtask

    task automatic model_update();
        bit fx = 0;
        bit fy = 0;
        if (mdx > 0) begin
            if (mx + STEP + SIZE <= H_VIS) mx += STEP;
            else begin mx = H_VIS - SIZE; mdx = -1; fx = 1; end
        end else begin
            if (mx >= STEP) mx -= STEP;
            else begin mx = 0; mdx = 1; fx = 1; end
        end
        if (mdy > 0) begin
            if (my + STEP + SIZE <= V_VIS) my += STEP;
            else begin my = V_VIS - SIZE; mdy = -1; fy = 1; end
        end else begin
            if (my >= STEP) my -= STEP;
            else begin my = 0; mdy = 1; fy = 1; end
        end
        if (fx || fy) mcol = (mcol + 1) % 8;
        last_flip = fx || fy;
    endtask

    task automatic drive(input int h, input int v, input logic hs, input logic vs, input logic e);
        @(negedge clk);
        h_count = 10'(h); v_count = 10'(v);
        hsync_in = hs; vsync_in = vs; en = e;
        if (e) begin
            exp_q.push_back({ref_pixel(h, v), hs, vs});
            if (h == 0 && v == V_VIS) model_update();
        end
    endtask

    task automatic probe_sprite();
        int px[6];
        int py[6];
        px = '{mx - 1, mx, mx + SIZE - 1, mx + SIZE, mx, mx + SIZE - 1};
        py = '{my, my, my + SIZE - 1, my + SIZE - 1, my - 1, my + SIZE};
        for (int i = 0; i < 6; i++)
            if (px[i] >= 0 && py[i] >= 0) drive(px[i], py[i], 1'($urandom), 1'($urandom), 1'b1);
        drive(mx + $urandom_range(0, SIZE - 1), my + $urandom_range(0, SIZE - 1), 1'b0, 1'b0, 1'b1);
        drive($urandom_range(0, 799), $urandom_range(0, 524), 1'($urandom), 1'($urandom), 1'b1);
    endtask

    // Monitor: after each edge, pop the expectation whose pixel has just reached the outputs.
    always @(posedge clk) begin
        logic [13:0] e;
        #1;
        if (!arst) begin
            check("frame_tick", 32'(frame_tick),
                  32'(en && h_count == 10'd0 && v_count == 10'(V_VIS)));
            if (en && exp_q.size() >= 2) begin
                e = exp_q.pop_front();
                hold_exp = e;
            end
            check("rgb", {20'd0, red, green, blue}, 32'(hold_exp[13:2]));
            check("hsync", 32'(hsync), 32'(hold_exp[1]));
            check("vsync", 32'(vsync), 32'(hold_exp[0]));
        end
    end

    initial begin
        model_reset();
        #5 arst = 1'b1;
        #30;
        check("reset_rgb", {20'd0, red, green, blue}, 32'd0);
        check("reset_sync", {30'd0, hsync, vsync}, 32'd0);
        check("reset_tick", 32'(frame_tick), 32'd0);
        @(negedge clk); arst = 1'b0;

        // Sprite origin and its edges right after reset.
        drive(0, 0, 1'b0, 1'b0, 1'b1);
        drive(31, 0, 1'b0, 1'b0, 1'b1);
        drive(32, 0, 1'b0, 1'b0, 1'b1);
        drive(0, 31, 1'b0, 1'b0, 1'b1);
        drive(0, 32, 1'b0, 1'b0, 1'b1);
        drive(31, 31, 1'b0, 1'b0, 1'b1);

        // Horizontal and vertical blanking with sync pulses.
        for (int h = 640; h < 800; h++) drive(h, 100, h >= 656 && h <= 751, 1'b0, 1'b1);
        for (int v = 480; v < 525; v++) drive(5, v, 1'b0, v >= 490 && v <= 491, 1'b1);

        // Long run of frames: covers right/bottom/left/top bounces and the corner at 13725.
        for (int n = 1; n <= 13800; n++) begin
            drive(0, V_VIS, 1'b0, 1'b0, 1'b1);
            drive(1, V_VIS + 1, 1'b0, 1'b0, 1'b1);
            if (last_flip || n < 4 || n % 64 == 0 || (n >= 300 && n <= 308)) probe_sprite();
            if (n == 3000) begin
                drive(mx + 3, my + 3, 1'b1, 1'b0, 1'b1);
                for (int k = 0; k < 100; k++) begin
                    if (k % 25 == 0) drive(0, V_VIS, 1'b0, 1'b0, 1'b0);
                    else drive($urandom_range(0, 799), $urandom_range(0, 524),
                               1'($urandom), 1'($urandom), 1'b0);
                end
                probe_sprite();
            end
        end

        // Asynchronous reset mid-frame, between clock edges.
        drive(mx + 1, my + 1, 1'b1, 1'b1, 1'b1);
        drive(mx + 2, my + 2, 1'b1, 1'b1, 1'b1);
        drive(300, 200, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        #5 arst = 1'b1;
        #1;
        check("async_rgb", {20'd0, red, green, blue}, 32'd0);
        check("async_sync", {30'd0, hsync, vsync}, 32'd0);
        check("async_tick", 32'(frame_tick), 32'd0);
        model_reset();
        en = 1'b0;
        repeat (2) @(negedge clk);
        arst = 1'b0;

        drive(0, 0, 1'b0, 1'b0, 1'b1);
        drive(31, 31, 1'b0, 1'b0, 1'b1);
        drive(32, 0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 3; n++) begin
            drive(0, V_VIS, 1'b0, 1'b0, 1'b1);
            probe_sprite();
        end
        repeat (3) drive(700, 500, 1'b0, 1'b0, 1'b1);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
